// File: rtl/rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_packet_arbiter
// Purpose  : Packet-locked round-robin arbiter with a registered output stage
//            and a stall timeout that releases a starved grant.
// Revision : 1.0
// ============================================================================
module rr_packet_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_REQ-1:0]                              in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]                   in_data,
    input  logic [NUM_REQ-1:0]                              in_last,
    output logic [NUM_REQ-1:0]                              in_ready,
    output logic                                            out_valid,
    output logic [DATA_WIDTH-1:0]                           out_data,
    output logic                                            out_last,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] out_src,
    input  logic                                            out_ready,
    output logic                                            abort
);

    localparam int c_SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_SRC_W-1:0] c_LAST_IDX = c_SRC_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [c_SRC_W:0]   c_NUM_REQ  = (c_SRC_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_SRC_W-1:0]     r_grant, w_grant_nxt;
    logic [c_SRC_W-1:0]     r_ptr, w_ptr_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                   r_out_valid, w_out_valid_nxt;
    logic [DATA_WIDTH-1:0]  r_out_data, w_out_data_nxt;
    logic                   r_out_last, w_out_last_nxt;
    logic [c_SRC_W-1:0]     r_out_src, w_out_src_nxt;
    logic                   r_abort, w_abort_nxt;

    logic [NUM_REQ-1:0]     w_rot;
    logic [c_SRC_W-1:0]     w_off;
    logic [c_SRC_W:0]       w_sum;
    logic [c_SRC_W-1:0]     w_pick;
    logic [c_SRC_W-1:0]     w_grant_inc;
    logic [NUM_REQ-1:0]     w_gmask;
    logic                   w_gvalid;
    logic                   w_glast;
    logic [DATA_WIDTH-1:0]  w_gdata;
    logic                   w_space;
    logic                   w_xfer;

    // Rotate requests so offset 0 is the pointer, take the lowest set offset,
    // then map back to an absolute index modulo NUM_REQ.
    always_comb begin
        w_rot = NUM_REQ'({in_valid, in_valid} >> r_ptr);
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_SRC_W'(k);
            end
        end
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= c_NUM_REQ) ? c_SRC_W'(w_sum - c_NUM_REQ) : w_sum[c_SRC_W-1:0];
    end

    assign w_grant_inc = (r_grant == c_LAST_IDX) ? '0 : r_grant + 1'b1;
    assign w_gmask     = NUM_REQ'(1) << r_grant;
    assign w_gvalid    = |(in_valid & w_gmask);
    assign w_glast     = |(in_last & w_gmask);
    assign w_gdata     = DATA_WIDTH'(in_data >> (r_grant * DATA_WIDTH));
    assign w_space     = !r_out_valid || out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_abort_nxt     = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_out_src_nxt   = r_out_src;
        in_ready        = '0;
        w_xfer          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (|in_valid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (w_space) begin
                    in_ready = w_gmask;
                end
                w_xfer = w_gvalid && w_space;
                if (w_xfer) begin
                    w_cnt_nxt = '0;
                    if (w_glast) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_grant_inc;
                    end
                end else if (!w_gvalid) begin
                    // A word waiting on a blocked output is not a stall.
                    if (r_cnt == c_CNT_MAX) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_grant_inc;
                        w_abort_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_xfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_gdata;
            w_out_last_nxt  = w_glast;
            w_out_src_nxt   = r_grant;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_src   <= w_out_src_nxt;
            r_abort     <= w_abort_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign abort     = r_abort;

endmodule
`default_nettype wire
